sc_regshift_out: RTL and testbench



---
 rtl/sc_regshift_pkg.sv | 21 ++
 rtl/sc_regshift_tick.sv | 42 ++++
 rtl/sc_regshift_out.sv | 149 ++++++++++++++
 tb/tb_sc_regshift_out.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_regshift_pkg.sv
// Shared definitions for the serial readout datapath: state encoding,
// line idle level and the bit-cycle counter width helper.
package sc_regshift_pkg;

    // 3-bit state encoding; PARITY is only reachable when parity is built in
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    // Serial line level when no frame is being sent
    localparam logic IDLE_LEVEL = 1'b1;

    // Width of a counter that spans 0..cycles-1, never narrower than one bit
    function automatic int unsigned cntWidth(input int unsigned cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sc_regshift_tick.sv
// Bit-cycle counter: counts 0..BitCycles-1 and wraps, flagging the last
// cycle of each serial bit. Held at zero while clear_i is high.
module sc_regshift_tick
    import sc_regshift_pkg::*;
#(
    parameter int unsigned BitCycles = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic bitEnd_o
);

    localparam int unsigned CntW = cntWidth(BitCycles);
    localparam logic [CntW-1:0] CntMax = CntW'(BitCycles - 1);

    logic [CntW-1:0] cntQ;
    logic [CntW-1:0] cntD;

    // Last cycle of the current bit
    always_comb begin
        bitEnd_o = (cntQ == CntMax);
    end

    // Next count: clear, wrap at the end of a bit, otherwise advance
    always_comb begin
        cntD = cntQ + 1'b1;
        if (clear_i || bitEnd_o) begin
            cntD = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

endmodule

// File: rtl/sc_regshift_out.sv
// Serial readout of the parallel register bus: UART-like frame, LSB first,
// BIT_CYCLES clocks per bit, started by an active-low request in IDLE.
// Optional even-parity bit between data and stop: SC_REGSHIFT_OUT_PARITY_EN.
module sc_regshift_out
    import sc_regshift_pkg::*;
#(
    parameter int unsigned DATAWIDTH  = 8,
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic                 SC_REGSHIFT_OUT_CLOCK_50,
    input  logic                 SC_REGSHIFT_OUT_RESET_InLow,
    input  logic                 SC_REGSHIFT_OUT_start_InLow,
    input  logic [DATAWIDTH-1:0] SC_REGSHIFT_OUT_data_InBUS,
    output logic                 SC_REGSHIFT_OUT_serial_Out,
    output logic                 SC_REGSHIFT_OUT_busy_Out,
    output logic                 SC_REGSHIFT_OUT_done_OutLow
);

    localparam int unsigned IdxW = $clog2(DATAWIDTH) + 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATAWIDTH - 1);

    logic [2:0]           stateQ, stateD;
    logic [DATAWIDTH-1:0] shiftQ, shiftD;
    logic [IdxW-1:0]      idxQ, idxD;
    logic                 serialQ, serialD;
    logic                 busyQ, busyD;
    logic                 doneQ, doneD;
    logic                 bitEnd;
    logic                 tickClear;
`ifdef SC_REGSHIFT_OUT_PARITY_EN
    logic                 parityQ, parityD;
`endif

    // Bit timing only runs while a bit is on the line
    always_comb begin
        tickClear = (stateQ == IDLE) || (stateQ == DONE);
    end

    sc_regshift_tick #(
        .BitCycles (BIT_CYCLES)
    ) u_tick (
        .clk_i    (SC_REGSHIFT_OUT_CLOCK_50),
        .rst_ni   (SC_REGSHIFT_OUT_RESET_InLow),
        .clear_i  (tickClear),
        .bitEnd_o (bitEnd)
    );

    // Frame sequencing, word capture and shifting
    always_comb begin
        stateD = stateQ;
        shiftD = shiftQ;
        idxD   = idxQ;
`ifdef SC_REGSHIFT_OUT_PARITY_EN
        parityD = parityQ;
`endif
        case (stateQ)
            IDLE: begin
                if (!SC_REGSHIFT_OUT_start_InLow) begin
                    shiftD = SC_REGSHIFT_OUT_data_InBUS;
                    idxD   = '0;
`ifdef SC_REGSHIFT_OUT_PARITY_EN
                    parityD = ^SC_REGSHIFT_OUT_data_InBUS;
`endif
                    stateD = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    stateD = DATA;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shiftD = shiftQ >> 1;
                    idxD   = idxQ + 1'b1;
                    if (idxQ == LastIdx) begin
`ifdef SC_REGSHIFT_OUT_PARITY_EN
                        stateD = PARITY;
`else
                        stateD = STOP;
`endif
                    end
                end
            end
`ifdef SC_REGSHIFT_OUT_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    stateD = STOP;
                end
            end
`endif
            STOP: begin
                if (bitEnd) begin
                    stateD = DONE;
                end
            end
            DONE: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Outputs decoded from the next state so they are registered yet aligned
    always_comb begin
        case (stateD)
            START:   serialD = 1'b0;
            DATA:    serialD = shiftD[0];
`ifdef SC_REGSHIFT_OUT_PARITY_EN
            PARITY:  serialD = parityD;
`endif
            default: serialD = IDLE_LEVEL;
        endcase
        busyD = (stateD != IDLE);
        doneD = (stateD != DONE);
    end

    // State and output registers; reset abandons any partial frame
    always_ff @(posedge SC_REGSHIFT_OUT_CLOCK_50 or negedge SC_REGSHIFT_OUT_RESET_InLow) begin
        if (!SC_REGSHIFT_OUT_RESET_InLow) begin
            stateQ  <= IDLE;
            shiftQ  <= '0;
            idxQ    <= '0;
            serialQ <= IDLE_LEVEL;
            busyQ   <= 1'b0;
            doneQ   <= 1'b1;
`ifdef SC_REGSHIFT_OUT_PARITY_EN
            parityQ <= 1'b0;
`endif
        end else begin
            stateQ  <= stateD;
            shiftQ  <= shiftD;
            idxQ    <= idxD;
            serialQ <= serialD;
            busyQ   <= busyD;
            doneQ   <= doneD;
`ifdef SC_REGSHIFT_OUT_PARITY_EN
            parityQ <= parityD;
`endif
        end
    end

    assign SC_REGSHIFT_OUT_serial_Out  = serialQ;
    assign SC_REGSHIFT_OUT_busy_Out    = busyQ;
    assign SC_REGSHIFT_OUT_done_OutLow = doneQ;

endmodule

// File: tb/tb_sc_regshift_out.sv
// Scoreboard bench for sc_regshift_out: stimulus pushes hand-written frame
// patterns (transmit order, bit 0 first); a monitor checks each frame seen.
module tb_sc_regshift_out;

    localparam int unsigned DW = 8;
    localparam int unsigned BC = 4;
`ifdef SC_REGSHIFT_OUT_PARITY_EN
    localparam int unsigned FB = 11;
`else
    localparam int unsigned FB = 10;
`endif

    logic          clk = 1'b0;
    logic          rstN;
    logic          startN;
    logic [DW-1:0] data;
    logic          serial;
    logic          busy;
    logic          doneN;

    int compared   = 0;
    int mismatched = 0;
    logic [10:0] expQ[$];
    bit monEn     = 1'b0;
    bit monActive = 1'b0;
    bit checkGap  = 1'b0;
    int cycle     = 0;
    int doneCount = 0;
    int lastDoneCycle = -100;

    always #10 clk = ~clk;

    sc_regshift_out #(
        .DATAWIDTH  (DW),
        .BIT_CYCLES (BC)
    ) dut (
        .SC_REGSHIFT_OUT_CLOCK_50    (clk),
        .SC_REGSHIFT_OUT_RESET_InLow (rstN),
        .SC_REGSHIFT_OUT_start_InLow (startN),
        .SC_REGSHIFT_OUT_data_InBUS  (data),
        .SC_REGSHIFT_OUT_serial_Out  (serial),
        .SC_REGSHIFT_OUT_busy_Out    (busy),
        .SC_REGSHIFT_OUT_done_OutLow (doneN)
    );

    always @(negedge clk) begin
        cycle <= cycle + 1;
        if (!doneN) doneCount <= doneCount + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Frame patterns, hand-derived: {stop, [parity,] data MSB..LSB, start}
    function automatic logic [10:0] frameOf(input logic [7:0] d);
        logic [10:0] f;
        f = '1;
        case (d)
`ifdef SC_REGSHIFT_OUT_PARITY_EN
            8'hA5: f = 11'b1_0_10100101_0;
            8'h3C: f = 11'b1_0_00111100_0;
            8'h01: f = 11'b1_1_00000001_0;
            8'h52: f = 11'b1_1_01010010_0;
            8'h07: f = 11'b1_1_00000111_0;
            8'h03: f = 11'b1_0_00000011_0;
`else
            8'hA5: f = {1'b0, 10'b1_10100101_0};
            8'h3C: f = {1'b0, 10'b1_00111100_0};
            8'h01: f = {1'b0, 10'b1_00000001_0};
            8'h52: f = {1'b0, 10'b1_01010010_0};
            8'h07: f = {1'b0, 10'b1_00000111_0};
            8'h03: f = {1'b0, 10'b1_00000011_0};
`endif
            default: f = '1;
        endcase
        return f;
    endfunction

    // Monitor: every busy rising edge is a frame to compare against the queue
    initial begin : monitor
        logic        prevBusy;
        logic [10:0] expv;
        int          startCycle;
        logic        bitOk;
        prevBusy = 1'b0;
        forever begin
            @(negedge clk);
            if (monEn && busy && !prevBusy) begin
                monActive  = 1'b1;
                startCycle = cycle;
                if (expQ.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    expv = '1;
                end else begin
                    expv = expQ.pop_front();
                end
                if (checkGap) check("frame_gap", startCycle - lastDoneCycle, 32'd2);
                for (int b = 0; b < FB; b++) begin
                    bitOk = 1'b1;
                    for (int c = 0; c < BC; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (serial !== expv[b] || busy !== 1'b1 || doneN !== 1'b1) bitOk = 1'b0;
                    end
                    check($sformatf("frame_bit%0d(exp %0b)", b, expv[b]), bitOk, 32'd1);
                end
                @(negedge clk);
                check("done_cycle{busy,done,ser}", {busy, doneN, serial}, 3'b101);
                lastDoneCycle = cycle;
                @(negedge clk);
                check("post_done_idle{busy,done,ser}", {busy, doneN, serial}, 3'b011);
                prevBusy  = busy;
                monActive = 1'b0;
            end else begin
                prevBusy = busy;
            end
        end
    end

    task automatic sendStart(input logic [7:0] d);
        @(posedge clk);
        #1;
        data   = d;
        startN = 1'b0;
        @(posedge clk);
        #1;
        startN = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] d);
        expQ.push_back(frameOf(d));
        sendStart(d);
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((expQ.size() != 0 || monActive) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", expQ.size() + int'(monActive), 32'd0);
        expQ.delete();
    endtask

    initial begin : stimulus
        int bad;
        int d0;
        int n;
        rstN   = 1'b0;
        startN = 1'b1;
        data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("in_reset{busy,done,ser}", {busy, doneN, serial}, 3'b011);
        rstN = 1'b1;

        // Idle line after reset with no request
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({busy, doneN, serial} !== 3'b011) bad++;
        end
        check("idle_100_bad_cycles", bad, 32'd0);
        monEn = 1'b1;

        // Basic frame
        sendFrame(8'hA5);
        waitDrain(200);

        // Request and data change mid-frame are ignored
        d0 = doneCount;
        sendFrame(8'h3C);
        repeat (10) @(posedge clk);
        #1;
        startN = 1'b0;
        data   = 8'hFF;
        @(posedge clk);
        #1;
        startN = 1'b1;
        waitDrain(200);
        repeat (5) @(posedge clk);
        check("busy_reject_no_frame", {monActive, busy}, 2'b00);
        check("busy_reject_done_count", doneCount - d0, 32'd1);

        // Request held low: back-to-back frames one idle cycle apart
        d0 = doneCount;
        repeat (3) expQ.push_back(frameOf(8'h01));
        @(posedge clk);
        #1;
        data   = 8'h01;
        startN = 1'b0;
        n = 0;
        while (!monActive && n < 50) begin
            @(posedge clk);
            n++;
        end
        checkGap = 1'b1;
        n = 0;
        while (doneCount < d0 + 2 && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        startN = 1'b1;
        waitDrain(400);
        checkGap = 1'b0;
        repeat (3) @(posedge clk);
        check("continuous_done_count", doneCount - d0, 32'd3);

        // Asynchronous reset during data bit 3 abandons the frame
        monEn = 1'b0;
        repeat (2) @(posedge clk);
        d0 = doneCount;
        sendStart(8'h52);
        repeat (17) @(posedge clk);
        #2;
        check("pre_reset_bit3{busy,ser}", {busy, serial}, 2'b10);
        rstN = 1'b0;
        #1;
        check("async_reset{busy,done,ser}", {busy, doneN, serial}, 3'b011);
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        repeat (3) @(posedge clk);
        check("abort_no_done", doneCount - d0, 32'd0);
        monEn = 1'b1;
        sendFrame(8'h52);
        waitDrain(200);

        // Parity-sensitive words (odd and even number of ones)
        sendFrame(8'h07);
        waitDrain(200);
        sendFrame(8'h03);
        waitDrain(200);

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
